mandelbrot_renderer: RTL
========================

# mandelbrot_renderer

Fixed-point Mandelbrot pixel engine that fills the 320x240 8-bit framebuffer with per-pixel escape counts. It is the framebuffer write-side producer and replaces the gradient test writer. It drives the framebuffer's `we/waddr/wdata` port directly, and raises `frame_done` for the display path's frame-valid latch. The colour LUT then maps each count to RGB.

## Interface
- `H_RES`, 320: pixels per row.
- `V_RES`, 240: rows per frame.
- `MAX_ITER`, 255: iteration limit, 1..255.
- `X_START`, -32768: real part of c at column 0, signed Q4.14 (-2.0).
- `Y_START`, -18480: imaginary part of c at row 0, signed Q4.14 (about -1.128).
- `STEP`, 154: c increment per column and per row, Q4.14 (about 0.0094).
- `clk`, in, 1: pixel clock, 25 MHz. All logic is on the rising edge.
- `reset`, in, 1: one clock; reset is synchronous and active-high.
- `start`, in, 1: single-cycle render request.
- `busy`, out, 1: high from the accepted `start` until the final write completes.
- `frame_done`, out, 1: latched high after the last pixel is written.
- `we`, out, 1: framebuffer write strobe.
- `waddr`, out, 17: framebuffer address, `y*H_RES + x`.
- `wdata`, out, 8: escape count. 0 means the point is in the set.

## Operation
- States: S_IDLE, S_INIT, S_ITER, S_WRITE, S_DONE.
- S_IDLE: wait here. `start` moves to S_INIT, loads pixel (0,0), sets `cx=X_START`, `cy=Y_START`, `addr=0`.
- S_INIT (1 cycle): set `zx=zy=0` and `iter=0`, then go to S_ITER.
- S_ITER (1 iteration per cycle), evaluated from the current z:
  - Escape test: `mag = (zx²>>>14) + (zy²>>>14)`. Escape when `mag > 65536` (4.0).
  - On escape: latch `wdata=iter[7:0]`.
  - Else if `iter == MAX_ITER`: latch `wdata=0`.
  - In either terminating case: latch `waddr=addr`, set `we<=1`, go to S_WRITE.
  - Otherwise update: `zx' = (zx²>>>14) - (zy²>>>14) + cx`, `zy' = ((zx*zy)>>>13) + cy`, `iter+1`.
- S_WRITE (1 cycle, `we=1`): advance to the next pixel.
  - Same row: `x+1`, `cx+=STEP`, `addr+1`.
  - End of row (`x==H_RES-1`): `x=0`, `cx=X_START`, `y+1`, `cy+=STEP`, `addr+1`.
  - Last pixel (`x==H_RES-1` and `y==V_RES-1`): go to S_DONE. Otherwise go to S_INIT.
- S_DONE: `frame_done=1`, `busy=0`, `we=0`.
  - `start` here clears `frame_done` and restarts the frame exactly as from S_IDLE.
- `start` while `busy` is ignored and has no effect.
- Arithmetic widths:
  - `zx`, `zy`, `cx`, `cy` are 18-bit signed. Products are 36-bit signed, arithmetic shifted, then resized.
  - `mag` is compared at 23 bits, unsigned-safe.
  - The update only happens when |z| ≤ 2, so |z'| < 8 and no saturation is needed.
  - `cx`/`cy` accumulate in 18-bit registers. The parameters must keep the endpoints within ±8.
- `addr` is a 17-bit counter, never a multiplier. Its maximum is 76799.

## Timing
- Reset values: state S_IDLE, `busy=0`, `frame_done=0`, `we=0`, `waddr=0`, `wdata=0`, all counters 0.
- Reset mid-frame: takes effect on the next edge. The in-flight write is abandoned and `we` is low the following cycle.
- All outputs are registered.
- `busy` rises the cycle after `start` is sampled.
- `we` is high for exactly one cycle per pixel, coincident with S_WRITE. `waddr`/`wdata` are stable for that cycle.
- Per-pixel cost: 1 (INIT) + (k+1) (ITER) + 1 (WRITE) cycles, where k = the written count, or MAX_ITER for in-set pixels.
- Writes are strictly ascending, with no gaps and no repeats.
- `frame_done` rises the cycle after the write to address 76799.
- The framebuffer accepts a write every cycle, so no backpressure exists.

## Structure
- Package `mandelbrot_pkg` holds:
  - FRAC=14, QW=18, ESCAPE_MAG=65536.
  - The state enum.
  - The 17-bit address type.
- Sub-module `mandel_iter_step`, purely combinational: inputs `zx`, `zy`, `cx`, `cy`; outputs `zx_next`, `zy_next`, `escape`. It holds the three multipliers, the shifts, and the compare.
- The top FSM keeps all registers, the pixel and c accumulators, and the address counter.

## Test plan
- Defaults, `start` after reset: first write is `waddr=0`, `wdata=1`, `we` high in the 4th cycle after `start` (c=(-2,-1.128) escapes at iter 1).
- `X_START=0`, `Y_START=0`, `MAX_ITER=15`, `H_RES=4`, `V_RES=2`: pixel 0 writes `wdata=0` after 15+1 ITER cycles. The total frame is 8 ascending writes, 0..7, then `frame_done=1`.
- Full default frame: exactly 76800 single-cycle writes, addresses 0..76799 with no gaps. Every `wdata` matches a bit-exact reference model. `busy` falls as `frame_done` rises.
- `start` pulsed while `busy`: no restart and the address sequence continues unchanged. `start` in S_DONE clears `frame_done` next cycle and the first write is `waddr=0` again.
- `reset` asserted mid-ITER at pixel 1000: next cycle `we=0`, `busy=0`, `waddr=0`, `frame_done=0`. A fresh `start` rewrites from address 0.
- `H_RES=3`, `V_RES=3`, `STEP=4096` (0.25): at the row wrap, `cx` returns to `X_START` and `cy` increases by 4096. `waddr` runs 2 → 3 across the wrap.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot pixel engine.
// Coordinates are signed Q4.14 held in 18 bits; escape radius is |z|^2 > 4.0.
package mandelbrot_pkg;

  localparam int FRAC       = 14;
  localparam int QW         = 18;
  localparam int ESCAPE_MAG = 65536;
  localparam int AW         = 17;
  localparam int MAGW       = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_WRITE,
    S_DONE
  } state_e;

  typedef logic [AW-1:0]        addr_t;
  typedef logic signed [QW-1:0] coord_t;

endpackage

// File: rtl/mandel_iter_step.sv
// One combinational Mandelbrot iteration: z' = z^2 + c plus the escape test on the current z.
// Squares are floored back to Q4.14; the cross term uses >>>13 to fold in the factor of two.
module mandel_iter_step
  import mandelbrot_pkg::*;
(
  input  logic signed [QW-1:0] zx,
  input  logic signed [QW-1:0] zy,
  input  logic signed [QW-1:0] cx,
  input  logic signed [QW-1:0] cy,
  output logic signed [QW-1:0] zx_next,
  output logic signed [QW-1:0] zy_next,
  output logic                 escape
);

  logic signed [2*QW-1:0] w_zx_ext;
  logic signed [2*QW-1:0] w_zy_ext;
  logic signed [2*QW-1:0] w_zx_sq;
  logic signed [2*QW-1:0] w_zy_sq;
  logic signed [2*QW-1:0] w_zxzy;
  logic signed [2*QW-1:0] w_zx_sq_q;
  logic signed [2*QW-1:0] w_zy_sq_q;
  logic signed [2*QW-1:0] w_zxzy_q;
  logic [MAGW-1:0]        w_mag;
  logic                   w_unused;

  assign w_zx_ext = {{QW{zx[QW-1]}}, zx};
  assign w_zy_ext = {{QW{zy[QW-1]}}, zy};

  assign w_zx_sq = w_zx_ext * w_zx_ext;
  assign w_zy_sq = w_zy_ext * w_zy_ext;
  assign w_zxzy  = w_zx_ext * w_zy_ext;

  assign w_zx_sq_q = w_zx_sq >>> FRAC;
  assign w_zy_sq_q = w_zy_sq >>> FRAC;
  assign w_zxzy_q  = w_zxzy >>> (FRAC - 1);

  // Squares are non-negative and below 2^21 for any 18-bit z, so 23 bits cannot wrap.
  assign w_mag  = w_zx_sq_q[MAGW-1:0] + w_zy_sq_q[MAGW-1:0];
  assign escape = (w_mag > MAGW'(ESCAPE_MAG));

  assign zx_next = w_zx_sq_q[QW-1:0] - w_zy_sq_q[QW-1:0] + cx;
  assign zy_next = w_zxzy_q[QW-1:0] + cy;

  assign w_unused = ^{w_zx_sq_q[2*QW-1:MAGW], w_zy_sq_q[2*QW-1:MAGW], w_zxzy_q[2*QW-1:QW]};

endmodule

// File: rtl/mandelbrot_renderer.sv
// Framebuffer producer: walks every pixel in raster order, iterates z = z^2 + c one step
// per cycle, and writes the escape count (0 = in set) to y*H_RES + x.
module mandelbrot_renderer
  import mandelbrot_pkg::*;
#(
  parameter int H_RES    = 320,
  parameter int V_RES    = 240,
  parameter int MAX_ITER = 255,
  parameter int X_START  = -32768,
  parameter int Y_START  = -18480,
  parameter int STEP     = 154
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  state_e         r_state;
  state_e         w_state_next;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  coord_t         r_cx;
  coord_t         r_cy;
  coord_t         r_zx;
  coord_t         r_zy;
  logic [7:0]     r_iter;
  addr_t          r_addr;
  addr_t          r_waddr;
  logic [7:0]     r_wdata;
  logic           r_we;
  logic           r_busy;
  logic           r_frame_done;
  logic           w_busy_next;
  logic           w_frame_done_next;
  logic           w_we_next;
  coord_t         w_zx_next;
  coord_t         w_zy_next;
  logic           w_escape;
  logic           w_iter_max;
  logic           w_row_end;
  logic           w_last_pixel;

  mandel_iter_step u_step (
    .zx      (r_zx),
    .zy      (r_zy),
    .cx      (r_cx),
    .cy      (r_cy),
    .zx_next (w_zx_next),
    .zy_next (w_zy_next),
    .escape  (w_escape)
  );

  assign w_iter_max   = (r_iter == 8'(MAX_ITER));
  assign w_row_end    = (r_x == XW'(H_RES - 1));
  assign w_last_pixel = w_row_end && (r_y == YW'(V_RES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_INIT;
      S_INIT:  w_state_next = S_ITER;
      S_ITER:  if (w_escape || w_iter_max) w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last_pixel ? S_DONE : S_INIT;
      S_DONE:  if (start) w_state_next = S_INIT;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered yet line up with it.
  always_comb begin
    w_busy_next       = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
    w_frame_done_next = (w_state_next == S_DONE);
    w_we_next         = (w_state_next == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_we         <= 1'b0;
    end else begin
      r_busy       <= w_busy_next;
      r_frame_done <= w_frame_done_next;
      r_we         <= w_we_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_zx    <= '0;
      r_zy    <= '0;
      r_iter  <= '0;
      r_addr  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_cx   <= QW'(X_START);
            r_cy   <= QW'(Y_START);
            r_addr <= '0;
          end
        end
        S_INIT: begin
          r_zx   <= '0;
          r_zy   <= '0;
          r_iter <= '0;
        end
        S_ITER: begin
          if (w_escape) begin
            r_wdata <= r_iter;
            r_waddr <= r_addr;
          end else if (w_iter_max) begin
            r_wdata <= '0;
            r_waddr <= r_addr;
          end else begin
            r_zx   <= w_zx_next;
            r_zy   <= w_zy_next;
            r_iter <= r_iter + 8'd1;
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + addr_t'(1);
          if (w_row_end) begin
            r_x  <= '0;
            r_cx <= QW'(X_START);
            r_y  <= r_y + YW'(1);
            r_cy <= r_cy + QW'(STEP);
          end else begin
            r_x  <= r_x + XW'(1);
            r_cx <= r_cx + QW'(STEP);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;

endmodule
